// File: rtl/uart_tx_arbiter_if.sv
// Bundle between the frame producers, the arbiter and the UART transmitter.
// Latency: none; this only groups the signals.
// Backpressure: producers hold req until ack; the transmitter stalls the arbiter with tx_busy.
interface uart_tx_arbiter_if #(
  parameter int NUM_REQ     = 4,
  parameter int FRAME_BYTES = 8
);
  logic [NUM_REQ-1:0]               req;
  logic [NUM_REQ*FRAME_BYTES*8-1:0] frame_data;
  logic [NUM_REQ-1:0]               ack;
  logic [NUM_REQ-1:0]               done;
  logic                             err;
  logic [2:0]                       err_id;
  logic                             busy;
  logic [7:0]                       tx_din;
  logic                             tx_wr_en;
  logic                             tx_busy;

  // Arbiter side: consumes requests and frames, drives the transmitter.
  modport master (
    input  req, frame_data, tx_busy,
    output ack, done, err, err_id, busy, tx_din, tx_wr_en
  );

  // Environment side: producers plus the transmitter.
  modport slave (
    output req, frame_data, tx_busy,
    input  ack, done, err, err_id, busy, tx_din, tx_wr_en
  );
endinterface

// File: rtl/uart_tx_arbiter.sv
// Round-robin arbiter that latches one whole frame per grant and feeds it byte by byte to a shared UART transmitter.
// Latency: req seen in IDLE -> ack next cycle, tx_wr_en one cycle later; next byte one cycle after tx_busy falls.
// Backpressure: no grant while tx_busy is high; each byte waits for tx_busy to rise then fall, aborting if it never rises.
module uart_tx_arbiter #(
  parameter int NUM_REQ      = 4,
  parameter int FRAME_BYTES  = 8,
  parameter int BUSY_TIMEOUT = 64
) (
  input  logic              clk,
  input  logic              rst,
  uart_tx_arbiter_if.master bus
);
  localparam int IW = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;
  localparam int BW = (FRAME_BYTES > 1) ? $clog2(FRAME_BYTES) : 1;
  localparam int TW = $clog2(BUSY_TIMEOUT + 1);
  localparam int FW = FRAME_BYTES * 8;

  typedef enum logic [1:0] {IDLE, SEND, WAIT_HI, WAIT_LO} state_t;

  state_t             state_q, state_d;
  logic [FW-1:0]      frame_q, frame_d;
  logic [IW-1:0]      last_q, last_d;
  logic [BW-1:0]      byte_idx_q, byte_idx_d;
  logic [TW-1:0]      timer_q, timer_d;
  logic [NUM_REQ-1:0] ack_q, ack_d;
  logic [NUM_REQ-1:0] done_q, done_d;
  logic               err_q, err_d;
  logic [2:0]         err_id_q, err_id_d;
  logic [7:0]         tx_din_q, tx_din_d;
  logic               tx_wr_en_q, tx_wr_en_d;

  logic               grant_vld;
  logic [IW-1:0]      grant_idx;

  // Pick the first requester after the previous winner, wrapping around; last_q also names the frame in flight.
  always_comb begin
    int idx;
    idx       = 0;
    grant_vld = 1'b0;
    grant_idx = '0;
    for (int k = 1; k <= NUM_REQ; k++) begin
      idx = (int'(last_q) + k) % NUM_REQ;
      if (!grant_vld && bus.req[idx]) begin
        grant_vld = 1'b1;
        grant_idx = IW'(idx);
      end
    end
  end

  // Frame FSM: grant and latch, strobe one byte, wait for the transmitter to take it, repeat.
  always_comb begin
    state_d    = state_q;
    frame_d    = frame_q;
    last_d     = last_q;
    byte_idx_d = byte_idx_q;
    timer_d    = timer_q;
    ack_d      = '0;
    done_d     = '0;
    err_d      = 1'b0;
    err_id_d   = err_id_q;
    tx_din_d   = tx_din_q;
    tx_wr_en_d = 1'b0;
    case (state_q)
      IDLE: begin
        if (grant_vld && !bus.tx_busy) begin
          frame_d    = bus.frame_data[int'(grant_idx)*FW +: FW];
          ack_d      = NUM_REQ'(1) << grant_idx;
          last_d     = grant_idx;
          byte_idx_d = '0;
          state_d    = SEND;
        end
      end
      SEND: begin
        tx_wr_en_d = 1'b1;
        tx_din_d   = frame_q[{byte_idx_q, 3'b000} +: 8];
        timer_d    = '0;
        state_d    = WAIT_HI;
      end
      WAIT_HI: begin
        if (bus.tx_busy) begin
          state_d = WAIT_LO;
        end else if (timer_q == TW'(BUSY_TIMEOUT - 1)) begin
          // Transmitter never accepted the byte: drop the rest of the frame.
          err_d    = 1'b1;
          err_id_d = 3'(last_q);
          state_d  = IDLE;
        end else begin
          timer_d = timer_q + 1'b1;
        end
      end
      WAIT_LO: begin
        if (!bus.tx_busy) begin
          if (byte_idx_q == BW'(FRAME_BYTES - 1)) begin
            done_d  = NUM_REQ'(1) << last_q;
            state_d = IDLE;
          end else begin
            byte_idx_d = byte_idx_q + 1'b1;
            state_d    = SEND;
          end
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // State and registered outputs; reset drops any frame in flight and points priority at requester 0.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= IDLE;
      frame_q    <= '0;
      last_q     <= IW'(NUM_REQ - 1);
      byte_idx_q <= '0;
      timer_q    <= '0;
      ack_q      <= '0;
      done_q     <= '0;
      err_q      <= 1'b0;
      err_id_q   <= '0;
      tx_din_q   <= '0;
      tx_wr_en_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      frame_q    <= frame_d;
      last_q     <= last_d;
      byte_idx_q <= byte_idx_d;
      timer_q    <= timer_d;
      ack_q      <= ack_d;
      done_q     <= done_d;
      err_q      <= err_d;
      err_id_q   <= err_id_d;
      tx_din_q   <= tx_din_d;
      tx_wr_en_q <= tx_wr_en_d;
    end
  end

  assign bus.ack      = ack_q;
  assign bus.done     = done_q;
  assign bus.err      = err_q;
  assign bus.err_id   = err_id_q;
  assign bus.busy     = (state_q != IDLE);
  assign bus.tx_din   = tx_din_q;
  assign bus.tx_wr_en = tx_wr_en_q;
endmodule

// File: tb/tb_uart_tx_arbiter.sv
// Bench for uart_tx_arbiter: producer stimulus, a simple UART transmitter model and a round-robin reference.
// Latency: outputs sampled 2 time units after the falling edge; inputs driven at the same point.
// Backpressure: the transmitter model raises tx_busy one cycle after each write, for BL cycles.
module tb_uart_tx_arbiter;
  localparam int NR      = 4;
  localparam int FB      = 8;
  localparam int TO      = 64;
  localparam int BL      = 10;
  localparam int WAITMAX = 400;

  logic clk = 1'b0;
  logic rst = 1'b1;
  int errors = 0;
  int checks = 0;

  uart_tx_arbiter_if #(.NUM_REQ(NR), .FRAME_BYTES(FB)) bus ();

  uart_tx_arbiter #(.NUM_REQ(NR), .FRAME_BYTES(FB), .BUSY_TIMEOUT(TO)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus.master)
  );

  always #5 clk = ~clk;

  logic [7:0] frames [NR][FB];
  int   cyc = 0;
  int   tx_mode = 0;          // 0: normal transmitter, 1: never busy, 2: tx_busy = force_busy
  logic force_busy = 1'b0;
  int   busy_cnt = 0;
  bit   pending = 1'b0;
  int   excl_viol = 0;
  int   wr_busy_viol = 0;

  logic [7:0] wr_q[$];
  int wr_cyc[$];
  int ack_q[$];
  int ack_cyc[$];
  int done_q[$];
  int err_q[$];
  int err_cyc[$];

  function automatic int oh2i(input logic [NR-1:0] v);
    for (int i = 0; i < NR; i++) if (v[i]) return i;
    return -1;
  endfunction

  // Reference round robin: first set bit after 'last', wrapping.
  function automatic int rr_next(input int last, input logic [NR-1:0] m);
    for (int k = 1; k <= NR; k++) if (m[(last + k) % NR]) return (last + k) % NR;
    return -1;
  endfunction

  task automatic drive_frames();
    for (int i = 0; i < NR; i++)
      for (int b = 0; b < FB; b++)
        bus.frame_data[(i*FB + b)*8 +: 8] = frames[i][b];
  endtask

  task automatic randomize_frames();
    for (int i = 0; i < NR; i++)
      for (int b = 0; b < FB; b++)
        frames[i][b] = 8'($urandom);
    drive_frames();
  endtask

  task automatic step();
    @(negedge clk);
    #2;
  endtask

  task automatic do_reset();
    step();
    rst = 1'b1;
    bus.req = '0;
    repeat (2) step();
    rst = 1'b0;
  endtask

  task automatic wait_ack(input int max, output int idx);
    idx = -1;
    for (int i = 0; i < max; i++) begin
      step();
      if (bus.ack != '0) begin idx = oh2i(bus.ack); return; end
    end
  endtask

  task automatic wait_done(input int max, output int idx);
    idx = -1;
    for (int i = 0; i < max; i++) begin
      step();
      if (bus.done != '0) begin idx = oh2i(bus.done); return; end
    end
  endtask

  task automatic wait_err(input int max, output int id);
    id = -1;
    for (int i = 0; i < max; i++) begin
      step();
      if (bus.err) begin id = int'(bus.err_id); return; end
    end
  endtask

  // Monitor at the falling edge, then the transmitter model a little later.
  initial begin : mon_and_tx
    bus.tx_busy = 1'b0;
    forever begin
      @(negedge clk);
      cyc++;
      if (($countones(bus.ack) + $countones(bus.done) + (bus.err ? 1 : 0)) > 1) excl_viol++;
      if (bus.ack != '0) begin ack_q.push_back(oh2i(bus.ack)); ack_cyc.push_back(cyc); end
      if (bus.done != '0) done_q.push_back(oh2i(bus.done));
      if (bus.err) begin err_q.push_back(int'(bus.err_id)); err_cyc.push_back(cyc); end
      if (bus.tx_wr_en) begin
        wr_q.push_back(bus.tx_din);
        wr_cyc.push_back(cyc);
        if (bus.tx_busy) wr_busy_viol++;
      end
      #3;
      if (tx_mode == 0) begin
        if (busy_cnt > 0) begin
          busy_cnt--;
          if (busy_cnt == 0) bus.tx_busy = 1'b0;
        end else if (pending) begin
          bus.tx_busy = 1'b1;
          busy_cnt = BL;
          pending = 1'b0;
        end
        if (bus.tx_wr_en) pending = 1'b1;
      end else begin
        busy_cnt = 0;
        pending = 1'b0;
        bus.tx_busy = (tx_mode == 2) ? force_busy : 1'b0;
      end
    end
  end

  task automatic test_reset();
    rst = 1'b1;
    bus.req = '0;
    repeat (3) step();
    checks++; if (bus.busy !== 1'b0) begin errors++; $display("FAIL reset_busy: got %b want 0", bus.busy); end
    checks++; if (bus.ack !== '0) begin errors++; $display("FAIL reset_ack: got %b want 0", bus.ack); end
    checks++; if (bus.done !== '0) begin errors++; $display("FAIL reset_done: got %b want 0", bus.done); end
    checks++; if (bus.err !== 1'b0) begin errors++; $display("FAIL reset_err: got %b want 0", bus.err); end
    checks++; if (bus.err_id !== 3'd0) begin errors++; $display("FAIL reset_err_id: got %0d want 0", bus.err_id); end
    checks++; if (bus.tx_wr_en !== 1'b0) begin errors++; $display("FAIL reset_wr_en: got %b want 0", bus.tx_wr_en); end
    checks++; if (bus.tx_din !== 8'h00) begin errors++; $display("FAIL reset_tx_din: got %h want 00", bus.tx_din); end
    rst = 1'b0;
  endtask

  task automatic test_single();
    int ab, wb, idx, n;
    logic [7:0] e;
    do_reset();
    tx_mode = 0;
    randomize_frames();
    for (int b = 0; b < FB; b++) frames[0][b] = 8'h10 + 8'(b);
    drive_frames();
    ab = ack_q.size();
    wb = wr_q.size();
    bus.req = 4'b0001;
    wait_ack(1, idx);
    checks++; if (idx !== 0) begin errors++; $display("FAIL single_ack_latency: got %0d want 0", idx); end
    bus.req = '0;
    wait_done(WAITMAX, idx);
    checks++; if (idx !== 0) begin errors++; $display("FAIL single_done: got %0d want 0", idx); end
    checks++; if (bus.busy !== 1'b0) begin errors++; $display("FAIL single_busy_after_done: got %b want 0", bus.busy); end
    n = wr_q.size() - wb;
    checks++; if (n !== FB) begin errors++; $display("FAIL single_wr_count: got %0d want %0d", n, FB); end
    for (int b = 0; b < FB && b < n; b++) begin
      e = 8'h10 + 8'(b);
      checks++; if (wr_q[wb+b] !== e) begin errors++; $display("FAIL single_byte%0d: got %h want %h", b, wr_q[wb+b], e); end
    end
    checks++;
    if (ack_cyc.size() <= ab || n < 1) begin
      errors++; $display("FAIL single_wr_latency: ack or write missing");
    end else if (wr_cyc[wb] !== ack_cyc[ab] + 1) begin
      errors++; $display("FAIL single_wr_latency: got %0d cycles want 1", wr_cyc[wb] - ack_cyc[ab]);
    end
  endtask

  task automatic run_rounds(input string tag, input int n, input bit rnd, inout int last);
    logic [7:0] exp_b[$];
    logic [NR-1:0] req_n;
    int wb, idx, exp, got;
    wb = wr_q.size();
    for (int r = 0; r < n; r++) begin
      exp = rr_next(last, bus.req);
      if (exp < 0) exp = 0;
      for (int b = 0; b < FB; b++) exp_b.push_back(frames[exp][b]);
      wait_ack(WAITMAX, idx);
      checks++; if (idx !== exp) begin errors++; $display("FAIL %s_grant%0d: got %0d want %0d", tag, r, idx, exp); end
      // The granted frame is already latched; disturbing its source must not matter.
      for (int b = 0; b < FB; b++) frames[exp][b] = 8'($urandom);
      drive_frames();
      if (rnd) begin
        req_n = bus.req;
        if ($urandom_range(0, 1) == 0) req_n[exp] = 1'b0;
        req_n = req_n | (NR'($urandom) & NR'($urandom));
        if (req_n == '0) req_n[$urandom_range(0, NR-1)] = 1'b1;
        bus.req = req_n;
      end
      last = exp;
      wait_done(WAITMAX, idx);
      checks++; if (idx !== exp) begin errors++; $display("FAIL %s_done%0d: got %0d want %0d", tag, r, idx, exp); end
      if (r == n - 1) bus.req = '0;
    end
    got = wr_q.size() - wb;
    checks++; if (got !== n*FB) begin errors++; $display("FAIL %s_wr_count: got %0d want %0d", tag, got, n*FB); end
    for (int i = 0; i < n*FB && i < got; i++) begin
      checks++; if (wr_q[wb+i] !== exp_b[i]) begin errors++; $display("FAIL %s_byte%0d: got %h want %h", tag, i, wr_q[wb+i], exp_b[i]); end
    end
  endtask

  task automatic test_contention();
    int last;
    do_reset();
    randomize_frames();
    last = NR - 1;
    bus.req = 4'b1111;
    run_rounds("contention", 6, 1'b0, last);
  endtask

  task automatic test_random_rr();
    int last;
    do_reset();
    randomize_frames();
    last = NR - 1;
    bus.req = NR'($urandom_range(1, (1 << NR) - 1));
    run_rounds("random", 10, 1'b1, last);
  endtask

  task automatic test_rr_pointer();
    int idx, exp;
    do_reset();
    randomize_frames();
    bus.req = 4'b0100;
    wait_ack(WAITMAX, idx);
    checks++; if (idx !== 2) begin errors++; $display("FAIL rrptr_first: got %0d want 2", idx); end
    bus.req = '0;
    wait_done(WAITMAX, idx);
    bus.req = 4'b0101;
    exp = rr_next(2, 4'b0101);
    wait_ack(WAITMAX, idx);
    checks++; if (idx !== exp) begin errors++; $display("FAIL rrptr_second: got %0d want %0d", idx, exp); end
    bus.req = 4'b0100;
    wait_done(WAITMAX, idx);
    wait_ack(WAITMAX, idx);
    checks++; if (idx !== 2) begin errors++; $display("FAIL rrptr_third: got %0d want 2", idx); end
    bus.req = '0;
    wait_done(WAITMAX, idx);
    checks++; if (idx !== 2) begin errors++; $display("FAIL rrptr_done: got %0d want 2", idx); end
  endtask

  task automatic test_timeout();
    int idx, id, wb, db, eb, n;
    do_reset();
    randomize_frames();
    tx_mode = 1;
    wb = wr_q.size();
    db = done_q.size();
    eb = err_cyc.size();
    bus.req = 4'b0010;
    wait_ack(WAITMAX, idx);
    checks++; if (idx !== 1) begin errors++; $display("FAIL timeout_ack: got %0d want 1", idx); end
    bus.req = '0;
    wait_err(WAITMAX, id);
    checks++; if (id !== 1) begin errors++; $display("FAIL timeout_err_id: got %0d want 1", id); end
    n = wr_q.size() - wb;
    checks++; if (n !== 1) begin errors++; $display("FAIL timeout_wr_count: got %0d want 1", n); end
    checks++;
    if (n < 1 || err_cyc.size() <= eb) begin
      errors++; $display("FAIL timeout_delay: write or err missing");
    end else if (err_cyc[eb] - wr_cyc[wb] !== TO) begin
      errors++; $display("FAIL timeout_delay: got %0d cycles want %0d", err_cyc[eb] - wr_cyc[wb], TO);
    end
    checks++; if (done_q.size() !== db) begin errors++; $display("FAIL timeout_no_done: got %0d dones want 0", done_q.size() - db); end
    checks++; if (bus.busy !== 1'b0) begin errors++; $display("FAIL timeout_idle: got busy %b want 0", bus.busy); end
    tx_mode = 0;
    bus.req = 4'b1000;
    wait_ack(WAITMAX, idx);
    checks++; if (idx !== rr_next(1, 4'b1000)) begin errors++; $display("FAIL timeout_next_ack: got %0d want 3", idx); end
    bus.req = '0;
    wait_done(WAITMAX, idx);
    checks++; if (idx !== 3) begin errors++; $display("FAIL timeout_next_done: got %0d want 3", idx); end
    checks++; if (bus.err_id !== 3'd1) begin errors++; $display("FAIL timeout_err_id_hold: got %0d want 1", bus.err_id); end
  endtask

  task automatic test_reset_midframe();
    int idx, db, nw;
    do_reset();
    randomize_frames();
    tx_mode = 0;
    db = done_q.size();
    bus.req = 4'b0001;
    wait_ack(WAITMAX, idx);
    bus.req = '0;
    nw = 0;
    for (int i = 0; i < WAITMAX && nw < 4; i++) begin
      step();
      if (bus.tx_wr_en) nw++;
    end
    checks++; if (nw !== 4) begin errors++; $display("FAIL midrst_reach_byte3: got %0d writes want 4", nw); end
    rst = 1'b1;
    step();
    checks++; if (bus.busy !== 1'b0) begin errors++; $display("FAIL midrst_busy: got %b want 0", bus.busy); end
    checks++; if (bus.tx_wr_en !== 1'b0) begin errors++; $display("FAIL midrst_wr_en: got %b want 0", bus.tx_wr_en); end
    step();
    rst = 1'b0;
    repeat (30) step();
    checks++; if (done_q.size() !== db) begin errors++; $display("FAIL midrst_no_done: got %0d dones want 0", done_q.size() - db); end
    bus.req = 4'b0011;
    wait_ack(WAITMAX, idx);
    checks++; if (idx !== rr_next(NR-1, 4'b0011)) begin errors++; $display("FAIL midrst_ptr_reset: got %0d want 0", idx); end
    bus.req = 4'b0010;
    wait_done(WAITMAX, idx);
    wait_ack(WAITMAX, idx);
    checks++; if (idx !== 1) begin errors++; $display("FAIL midrst_second: got %0d want 1", idx); end
    bus.req = '0;
    wait_done(WAITMAX, idx);
  endtask

  task automatic test_busy_block();
    int idx, ab;
    do_reset();
    randomize_frames();
    tx_mode = 2;
    force_busy = 1'b1;
    repeat (2) step();
    ab = ack_q.size();
    bus.req = 4'b0001;
    repeat (6) step();
    checks++; if (ack_q.size() !== ab) begin errors++; $display("FAIL busyblk_no_ack: got %0d acks want 0", ack_q.size() - ab); end
    checks++; if (bus.busy !== 1'b0) begin errors++; $display("FAIL busyblk_idle: got busy %b want 0", bus.busy); end
    force_busy = 1'b0;
    wait_ack(1, idx);
    checks++; if (idx !== 0) begin errors++; $display("FAIL busyblk_ack_after_release: got %0d want 0", idx); end
    bus.req = '0;
    tx_mode = 0;
    wait_done(WAITMAX, idx);
    checks++; if (idx !== 0) begin errors++; $display("FAIL busyblk_done: got %0d want 0", idx); end
  endtask

  task automatic test_invariants();
    checks++; if (excl_viol !== 0) begin errors++; $display("FAIL excl_ack_done_err: got %0d overlaps want 0", excl_viol); end
    checks++; if (wr_busy_viol !== 0) begin errors++; $display("FAIL wr_while_busy: got %0d writes want 0", wr_busy_viol); end
  endtask

  initial begin
    bus.req = '0;
    bus.frame_data = '0;
    test_reset();
    test_single();
    test_contention();
    test_rr_pointer();
    test_timeout();
    test_reset_midframe();
    test_busy_block();
    test_random_rr();
    test_invariants();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
